block_data_memory: RTL and testbench

//  Parametrised block-organised data memory behind the data cache; serves whole-block reads/writes.

---
 rtl/block_data_memory.sv | 163 ++++++++++++++++
 tb/tb_block_data_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_data_memory.sv
// block_data_memory: block-organised data memory that sits behind the data cache.
// Each access moves one whole block. A cycle counter sets the fixed access latency, and the
// requester holds read/write until busywait drops.
//
// Optional feature: define DMEM_BYTE_MASK_EN to add the byteenable port (per-byte write mask).
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high; clears FSM, counter, readdata, error flag and array
//   read         block read request, held until busywait is low
//   write        block write request, held until busywait is low
//   address      block address
//   writedata    write block; byte k = writedata[8k+7:8k]
//   byteenable   per-byte write enable (only with DMEM_BYTE_MASK_EN)
//   readdata     last block read; holds until the next read completes
//   busywait     high while an access is being accepted or is in progress
//   access_error one-cycle pulse after read and write were asserted together in idle
module block_data_memory #(
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned BLOCK_BYTES   = 16,
  parameter int unsigned READ_LATENCY  = 5,
  parameter int unsigned WRITE_LATENCY = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       read,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          address,
  input  logic [8*BLOCK_BYTES-1:0]   writedata,
`ifdef DMEM_BYTE_MASK_EN
  input  logic [BLOCK_BYTES-1:0]     byteenable,
`endif
  output logic [8*BLOCK_BYTES-1:0]   readdata,
  output logic                       busywait,
  output logic                       access_error
);

  localparam int unsigned DW     = 8 * BLOCK_BYTES;
  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam int unsigned MaxLat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                  : WRITE_LATENCY;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DW-1:0]          wdata_q;
  logic [BLOCK_BYTES-1:0] be_q;
  logic [DW-1:0]          readdata_q;
  logic                   access_error_q;
  logic [DW-1:0]          mem_q [Depth];

  logic accept_rd, accept_wr, commit_rd, commit_wr, req_conflict;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (read && !write) begin
          state_d = StRdWait;
        end else if (write && !read) begin
          state_d = StWrWait;
        end
      end
      StRdWait: if (cnt_q == '0) state_d = StDone;
      StWrWait: if (cnt_q == '0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and strobe logic
  always_comb begin
    busywait     = 1'b0;
    accept_rd    = 1'b0;
    accept_wr    = 1'b0;
    commit_rd    = 1'b0;
    commit_wr    = 1'b0;
    req_conflict = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Raised in the request cycle so the requester stalls immediately.
        busywait     = read ^ write;
        accept_rd    = read & ~write;
        accept_wr    = write & ~read;
        req_conflict = read & write;
      end
      StRdWait: begin
        busywait  = 1'b1;
        commit_rd = (cnt_q == '0);
      end
      StWrWait: begin
        busywait  = 1'b1;
        commit_wr = (cnt_q == '0);
      end
      // One guaranteed low cycle so a held request is not re-accepted.
      StDone:  busywait = 1'b0;
      default: busywait = 1'b0;
    endcase
    if (reset) begin
      busywait = 1'b0;
    end
  end

  // Datapath: request latch, latency counter, readdata and storage array
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      readdata_q     <= '0;
      access_error_q <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      access_error_q <= req_conflict;
      if (accept_rd) begin
        addr_q <= address;
        cnt_q  <= CntW'(READ_LATENCY - 1);
      end else if (accept_wr) begin
        addr_q  <= address;
        wdata_q <= writedata;
`ifdef DMEM_BYTE_MASK_EN
        be_q    <= byteenable;
`else
        be_q    <= '1;
`endif
        cnt_q   <= CntW'(WRITE_LATENCY - 1);
      end else if ((state_q == StRdWait || state_q == StWrWait) && cnt_q != '0) begin
        cnt_q <= cnt_q - CntW'(1);
      end

      if (commit_rd) begin
        readdata_q <= mem_q[addr_q];
      end
      if (commit_wr) begin
        for (int k = 0; k < int'(BLOCK_BYTES); k++) begin
          if (be_q[k]) begin
            mem_q[addr_q][8*k +: 8] <= wdata_q[8*k +: 8];
          end
        end
      end
    end
  end

  assign readdata     = readdata_q;
  assign access_error = access_error_q;

endmodule

// File: tb/tb_block_data_memory.sv
module tb_block_data_memory;

  localparam int unsigned AW = 4;
  localparam int unsigned BB = 16;
  localparam int unsigned DW = 8 * BB;
  localparam int unsigned RL = 5;
  localparam int unsigned WL = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
`ifdef DMEM_BYTE_MASK_EN
  logic [BB-1:0] byteenable;
`endif
  logic [DW-1:0] readdata;
  logic          busywait;
  logic          access_error;

  block_data_memory #(
    .ADDR_W        (AW),
    .BLOCK_BYTES   (BB),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
`ifdef DMEM_BYTE_MASK_EN
    .byteenable   (byteenable),
`endif
    .readdata     (readdata),
    .busywait     (busywait),
    .access_error (access_error)
  );

  always #5 clock = ~clock;

  // Reference model: plain array of blocks plus the last value read.
  logic [DW-1:0] mem_m [16];
  logic [DW-1:0] rd_m;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    rd_m = '0;
  endtask

  // One complete handshake. Inputs change 1 time unit after a rising edge; outputs are
  // sampled 1 time unit after that (well away from the next edge).
  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [BB-1:0] be,
                           input logic scramble);
    int n;
    logic [BB-1:0] eff_be;
    read      = rd;
    write     = wr;
    address   = addr;
    writedata = data;
`ifdef DMEM_BYTE_MASK_EN
    byteenable = be;
    eff_be     = be;
`else
    eff_be     = '1;
`endif
    #1;
    check_eq("busywait_request_cycle", DW'(busywait), DW'(rd ^ wr));
    @(posedge clock); #1;
    if (rd && wr) begin
      read  = 1'b0;
      write = 1'b0;
      #1;
      check_eq("access_error_pulse", DW'(access_error), DW'(1));
      check_eq("busywait_conflict", DW'(busywait), DW'(0));
      @(posedge clock); #1;
      check_eq("access_error_clears", DW'(access_error), DW'(0));
      check_eq("readdata_after_conflict", readdata, rd_m);
      return;
    end
    if (!rd && !wr) return;
    n = 0;
    while (busywait === 1'b1 && n < 64) begin
      if (scramble) begin
        address   = AW'($urandom);
        writedata = {$urandom, $urandom, $urandom, $urandom};
`ifdef DMEM_BYTE_MASK_EN
        byteenable = BB'($urandom);
`endif
      end
      n++;
      @(posedge clock); #1;
    end
    check_eq(rd ? "read_busy_cycles" : "write_busy_cycles", DW'(n), rd ? DW'(RL) : DW'(WL));
    if (wr) begin
      for (int k = 0; k < int'(BB); k++) begin
        if (eff_be[k]) mem_m[addr][8*k +: 8] = data[8*k +: 8];
      end
    end else begin
      rd_m = mem_m[addr];
    end
    // Still in the release cycle with the request held: data must already be final.
    check_eq("readdata", readdata, rd_m);
    read  = 1'b0;
    write = 1'b0;
    @(posedge clock); #1;
    check_eq("busywait_idle", DW'(busywait), DW'(0));
    check_eq("access_error_idle", DW'(access_error), DW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] pattern;
    model_reset();
    reset     = 1'b1;
    read      = 1'b1;  // reset must dominate a pending request
    write     = 1'b0;
    address   = 4'h3;
    writedata = '0;
`ifdef DMEM_BYTE_MASK_EN
    byteenable = '1;
`endif
    @(posedge clock); #1;
    check_eq("reset_busywait", DW'(busywait), DW'(0));
    @(posedge clock); #1;
    check_eq("reset_readdata", readdata, '0);
    check_eq("reset_access_error", DW'(access_error), DW'(0));
    reset = 1'b0;
    read  = 1'b0;
    @(posedge clock); #1;

    // Read of a reset block returns zero.
    do_access(1'b1, 1'b0, 4'h3, '0, '1, 1'b0);

    // Full-width write to the top block, then read it back.
    pattern = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    do_access(1'b0, 1'b1, 4'hF, pattern, '1, 1'b0);
    do_access(1'b1, 1'b0, 4'hF, '0, '1, 1'b0);
    check_eq("top_block_value", readdata, pattern);

    // Conflicting request: no access, array unchanged.
    do_access(1'b1, 1'b1, 4'hF, '1, '1, 1'b0);
    do_access(1'b1, 1'b0, 4'hF, '0, '1, 1'b0);

    // Inputs change mid-write: commit goes to the latched address with latched data.
    d = {$urandom, $urandom, $urandom, $urandom};
    read = 1'b0; write = 1'b1; address = 4'h2; writedata = d;
`ifdef DMEM_BYTE_MASK_EN
    byteenable = '1;
`endif
    #1;
    check_eq("busywait_request_cycle", DW'(busywait), DW'(1));
    @(posedge clock); #1;
    address   = 4'h5;
    writedata = ~d;
    begin
      int n;
      n = 0;
      while (busywait === 1'b1 && n < 64) begin
        n++;
        @(posedge clock); #1;
      end
      check_eq("mid_change_busy_cycles", DW'(n), DW'(WL));
    end
    mem_m[2] = d;
    write = 1'b0;
    @(posedge clock); #1;
    do_access(1'b1, 1'b0, 4'h2, '0, '1, 1'b0);
    do_access(1'b1, 1'b0, 4'h5, '0, '1, 1'b0);

`ifdef DMEM_BYTE_MASK_EN
    do_access(1'b0, 1'b1, 4'h4, {16{8'hAA}}, '1, 1'b0);
    do_access(1'b0, 1'b1, 4'h4, {16{8'h55}}, 16'h00F0, 1'b0);
    do_access(1'b1, 1'b0, 4'h4, '0, '1, 1'b0);
    check_eq("byte_mask_value", readdata, {{8{8'hAA}}, {4{8'h55}}, {4{8'hAA}}});
`endif

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      int op;
      op = $urandom_range(0, 9);
      do_access(op == 0 || (op >= 1 && op <= 4), op == 0 || op >= 5, AW'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, BB'($urandom),
                1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    // Make sure block 1 is non-zero, then interrupt a write to it with reset.
    do_access(1'b0, 1'b1, 4'h1, {4{32'hDEADBEEF}}, '1, 1'b0);
    read = 1'b0; write = 1'b1; address = 4'h1; writedata = {4{32'h12345678}};
`ifdef DMEM_BYTE_MASK_EN
    byteenable = '1;
`endif
    @(posedge clock); #1;
    repeat (3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    check_eq("busywait_during_reset", DW'(busywait), DW'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    write = 1'b0;
    model_reset();
    #1;
    check_eq("busywait_after_reset", DW'(busywait), DW'(0));
    check_eq("readdata_after_reset", readdata, '0);
    do_access(1'b1, 1'b0, 4'h1, '0, '1, 1'b0);
    do_access(1'b1, 1'b0, 4'hF, '0, '1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
